game_controller: RTL
====================

Name: game_controller

Overview:
- Round-level game FSM that sits directly downstream of the bubble array and drives it.
- Consumes the bubble array's per-pixel drawing request and its win flag, plus the player and arrow drawing requests.
- Produces the bubble array's start pulse, the gated arrow-hit signal, a round-reset strobe, and the score/timer state shown on the HUD.
- Performs per-frame collision latching; all frame-level decisions are taken on startOfFrame.

Parameters:
- LIVES, 3, lives loaded at power-up and on new game (1..3)
- ROUND_SECONDS, 60, timer reload value in seconds (1..127)
- FRAMES_PER_SEC, 30, startOfFrame pulses per timer decrement
- DEATH_FRAMES, 60, frames spent in DEATH before the round restarts
- WIN_FRAMES, 90, frames spent in WIN before returning to IDLE

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-clk pulse per frame (30 Hz)
- startKey  in  1  level from the debounced start key
- win  in  1  level from the bubble array; 1 when all bubbles are cleared
- bubbleDR  in  1  bubble array drawing request for the current pixel
- playerDR  in  1  player drawing request for the current pixel
- arrowDR  in  1  arrow drawing request for the current pixel
- arrowHit  out  1  combinational: arrowDR & bubbleDR & (state==RUN); drives the bubble array's arrowHit
- arrowClear  out  1  one-clk pulse that retracts the arrow
- bubbleStart  out  1  one-clk pulse that launches the first bubble
- roundResetN  out  1  active-low one-clk strobe, ANDed externally into the bubble array reset
- lives  out  2  remaining lives
- timeLeft  out  7  seconds remaining in the round
- state  out  3  IDLE=0, RUN=1, DEATH=2, WIN=3, GAMEOVER=4

Behaviour:
- Reset values:
  - state=IDLE, lives=LIVES, timeLeft=ROUND_SECONDS.
  - bubbleStart=0, arrowClear=0, roundResetN=1.
  - frame counter=0, hit latches=0, keyPrev=0.
- Key edge: keyRise = startKey & ~keyPrev; keyPrev is registered every clk.
- Collision latches (set only in RUN, cleared on every startOfFrame after being sampled):
  - pHit: set by playerDR & bubbleDR.
  - aHit: set by arrowDR & bubbleDR.
- arrowClear: pulses for 1 clk on a startOfFrame in RUN when aHit was set during the preceding frame. It also pulses in the clk of any transition out of RUN.
- Timer, RUN only:
  - The frame counter counts startOfFrame pulses, 0..FRAMES_PER_SEC-1.
  - On wrap, timeLeft decrements, saturating at 0.
  - The counter clears on every entry to RUN.
- IDLE: on keyRise, go to RUN, pulse bubbleStart in the same clk, reload timeLeft.
- RUN decisions, taken only on startOfFrame, in priority order:
  1. win=1 -> WIN.
  2. pHit=1 or timeLeft==0 -> lives decrements. If the new value is 0, go to GAMEOVER; otherwise go to DEATH.
  3. Otherwise stay in RUN.
  - win therefore beats a simultaneous death in the same frame.
- DEATH:
  - Counts DEATH_FRAMES startOfFrame pulses.
  - Then drives roundResetN=0 for exactly 1 clk (clk T).
  - bubbleStart=1 at T+1, with timeLeft reloaded and the frame counter cleared, and state=RUN at T+1.
- WIN:
  - Counts WIN_FRAMES pulses.
  - Then drives roundResetN=0 for 1 clk, reloads timeLeft, goes to IDLE.
  - lives are unchanged.
- GAMEOVER:
  - On keyRise: roundResetN=0 for 1 clk, lives=LIVES, timeLeft reload, go to IDLE.
  - A keyRise in the same clk as entry to GAMEOVER is ignored.
- Other rules:
  - keyRise outside IDLE/GAMEOVER is ignored.
  - bubbleStart and roundResetN are never asserted in the same clk.
  - The frame-wait counters are 8 bits and clear on state entry.
  - Asserting resetN mid-round returns all outputs to their reset values immediately; pending pulses are dropped.

Test Plan:
- Reset then keyRise in IDLE -> bubbleStart high for exactly 1 clk, state=1, timeLeft=60, lives=3.
- RUN, hold playerDR=bubbleDR=1 for 1 clk mid-frame -> next startOfFrame: lives=2, state=2, arrowClear pulse. After 60 frames: roundResetN low for 1 clk, then bubbleStart 1 clk later, state=1, timeLeft=60.
- RUN with no collisions for 30 frames -> timeLeft=59. Run 1800 frames -> timeLeft=0, then next startOfFrame causes a death.
- arrowDR=bubbleDR=1 in RUN -> arrowHit=1 in the same clk; arrowClear 1 clk at the next startOfFrame. In IDLE the same stimulus gives arrowHit=0.
- win=1 and pHit both set in one frame -> state=3, lives unchanged. After 90 frames: roundResetN strobe, state=0.
- Three deaths -> state=4, lives=0. keyRise -> roundResetN strobe, lives=3, state=0. Assert resetN low mid-DEATH -> state=0 and all pulses low at once.

Source files
------------

// File: rtl/game_controller_if.sv
// game_controller_if: per-pixel requests and frame/key inputs into the round FSM, plus its HUD and pulse outputs.
interface game_controller_if;
   logic       startOfFrame, startKey, win, bubbleDR, playerDR, arrowDR;
   logic       arrowHit, arrowClear, bubbleStart, roundResetN;
   logic [1:0] lives;
   logic [6:0] timeLeft;
   logic [2:0] state;
   modport master (
      output startOfFrame, startKey, win, bubbleDR, playerDR, arrowDR,
      input  arrowHit, arrowClear, bubbleStart, roundResetN, lives, timeLeft, state
   );
   modport slave (
      input  startOfFrame, startKey, win, bubbleDR, playerDR, arrowDR,
      output arrowHit, arrowClear, bubbleStart, roundResetN, lives, timeLeft, state
   );
endinterface

// File: rtl/game_controller.sv
// game_controller: round-level FSM driving the bubble array; latches collisions per frame, runs the round timer and lives.
module game_controller #(
   parameter int LIVES          = 3,
   parameter int ROUND_SECONDS  = 60,
   parameter int FRAMES_PER_SEC = 30,
   parameter int DEATH_FRAMES   = 60,
   parameter int WIN_FRAMES     = 90
) (
   input logic               clk,
   input logic               resetN,
   game_controller_if.slave  g
);
   localparam logic [2:0] IDLE = 3'd0, RUN = 3'd1, DEATH = 3'd2, WIN = 3'd3, GAMEOVER = 3'd4;
   localparam logic [1:0] LV0 = 2'(LIVES);
   localparam logic [6:0] TL0 = 7'(ROUND_SECONDS);
   localparam logic [7:0] FPS_M1 = 8'(FRAMES_PER_SEC - 1);
   localparam logic [7:0] DTH_M1 = 8'(DEATH_FRAMES - 1);
   localparam logic [7:0] WIN_M1 = 8'(WIN_FRAMES - 1);
   logic [2:0] st;
   logic [1:0] lv;
   logic [6:0] tl;
   logic [7:0] fcnt, wcnt;
   logic       key_prev, p_hit, a_hit, b_start, a_clear, rr_n, run, key_rise, sof;
   assign run      = st == RUN;
   assign sof      = g.startOfFrame;
   assign key_rise = g.startKey & ~key_prev;
   assign g.arrowHit    = g.arrowDR & g.bubbleDR & run;
   assign g.arrowClear  = a_clear;
   assign g.bubbleStart = b_start;
   assign g.roundResetN = rr_n;
   assign g.lives       = lv;
   assign g.timeLeft    = tl;
   assign g.state       = st;
   always_ff @(posedge clk or negedge resetN)
      if (!resetN) begin
         st       <= IDLE;
         lv       <= LV0;
         tl       <= TL0;
         fcnt     <= '0;
         wcnt     <= '0;
         key_prev <= 1'b0;
         p_hit    <= 1'b0;
         a_hit    <= 1'b0;
         b_start  <= 1'b0;
         a_clear  <= 1'b0;
         rr_n     <= 1'b1;
      end else begin
         key_prev <= g.startKey;
         b_start  <= 1'b0;
         a_clear  <= 1'b0;
         rr_n     <= 1'b1;
         p_hit    <= sof ? 1'b0 : p_hit | (run & g.playerDR & g.bubbleDR);
         a_hit    <= sof ? 1'b0 : a_hit | (run & g.arrowDR & g.bubbleDR);
         case (st)
            IDLE: if (key_rise) begin
               st      <= RUN;
               b_start <= 1'b1;
               tl      <= TL0;
               fcnt    <= '0;
            end
            RUN: if (sof) begin
               fcnt    <= fcnt == FPS_M1 ? 8'd0 : fcnt + 8'd1;
               if (fcnt == FPS_M1 && tl != 7'd0) tl <= tl - 7'd1;
               a_clear <= a_hit;
               wcnt    <= '0;
               // win outranks a death decided in the same frame
               if (g.win) begin
                  st      <= WIN;
                  a_clear <= 1'b1;
               end else if (p_hit || tl == 7'd0) begin
                  lv      <= lv - 2'd1;
                  st      <= lv == 2'd1 ? GAMEOVER : DEATH;
                  a_clear <= 1'b1;
               end
            end
            DEATH: if (!rr_n) begin
               st      <= RUN;
               b_start <= 1'b1;
               tl      <= TL0;
               fcnt    <= '0;
            end else if (sof) begin
               if (wcnt == DTH_M1) rr_n <= 1'b0;
               else wcnt <= wcnt + 8'd1;
            end
            WIN: if (sof) begin
               if (wcnt == WIN_M1) begin
                  rr_n <= 1'b0;
                  tl   <= TL0;
                  st   <= IDLE;
               end else wcnt <= wcnt + 8'd1;
            end
            GAMEOVER: if (key_rise) begin
               rr_n <= 1'b0;
               lv   <= LV0;
               tl   <= TL0;
               st   <= IDLE;
            end
            default: st <= IDLE;
         endcase
      end
endmodule
